// File: rtl/kmac_bytepad_if.sv
// kmac_bytepad_if: byte-in / lane-out handshake bundle for the bytepad packer.
//   start            frame request (one cycle)
//   in_valid/ready   encoded byte stream in, in_byte data, in_last marks end of X
//   out_valid/ready  64-bit lane out, out_word data, out_block_end / out_last flags
//   busy, done       frame status
// master = byte producer / lane consumer side, slave = packer side.
interface kmac_bytepad_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_word;
    logic        out_block_end;
    logic        out_last;
    logic        busy;
    logic        done;

    modport master (
        output start, in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_block_end, out_last, busy, done
    );

    modport slave (
        input  start, in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_word, out_block_end, out_last, busy, done
    );
endinterface

// File: rtl/kmac_bytepad_packer.sv
// kmac_bytepad_packer: bytepad(X, w) with w = RATE_BYTES. Emits left_encode(w)
// (0x01, w), then X, then zero padding up to a multiple of w, packed
// little-endian into 64-bit Keccak lanes.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  kmac_bytepad_if.slave (start, byte input, lane output, busy, done)
//
// state  | meaning
// IDLE   | waiting for start
// HDR0   | producing 0x01
// HDR1   | producing RATE_BYTES
// DATA   | forwarding input bytes until in_last
// PAD    | producing 0x00 until the block is full
// FLUSH  | waiting for the final lane to be accepted
module kmac_bytepad_packer #(
    parameter int unsigned RATE_BYTES = 168
) (
    input logic          clk,
    input logic          rst,
    kmac_bytepad_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_PAD, S_FLUSH} state_t;

    localparam logic [7:0] RATE_B   = 8'(RATE_BYTES);
    localparam logic [7:0] BLK_LAST = 8'(RATE_BYTES - 1);

    state_t      state_q, state_d;
    logic [63:0] lane_q, lane_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  blk_cnt_q, blk_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        blk_end_q, blk_end_d;
    logic        last_q, last_d;
    logic        done_q, done_d;

    logic        can_write;
    logic        in_ready;
    logic        prod;
    logic [7:0]  prod_byte;
    logic        final_blk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            byte_idx_q  <= '0;
            blk_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            blk_end_q   <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            byte_idx_q  <= byte_idx_d;
            blk_cnt_q   <= blk_cnt_d;
            out_valid_q <= out_valid_d;
            blk_end_q   <= blk_end_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        byte_idx_d  = byte_idx_q;
        blk_cnt_d   = blk_cnt_q;
        out_valid_d = out_valid_q;
        blk_end_d   = blk_end_q;
        last_d      = last_q;
        done_d      = 1'b0;
        prod        = 1'b0;
        prod_byte   = 8'h00;
        final_blk   = 1'b0;

        // A byte may only be produced when the lane register is free or is
        // being handed over this very cycle.
        can_write = !out_valid_q || bus.out_ready;
        in_ready  = (state_q == S_DATA) && can_write;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            blk_end_d   = 1'b0;
            last_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (can_write) begin
                    prod      = 1'b1;
                    prod_byte = 8'h01;
                    state_d   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (can_write) begin
                    prod      = 1'b1;
                    prod_byte = RATE_B;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.in_valid && in_ready) begin
                    prod      = 1'b1;
                    prod_byte = bus.in_byte;
                    if (bus.in_last) begin
                        final_blk = 1'b1;
                        state_d   = (blk_cnt_q == BLK_LAST) ? S_FLUSH : S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (can_write) begin
                    prod      = 1'b1;
                    final_blk = 1'b1;
                    if (blk_cnt_q == BLK_LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shifting in from the top leaves the first byte of the lane in [7:0]
        // once eight bytes have gone in.
        if (prod) begin
            lane_d     = {prod_byte, lane_q[63:8]};
            byte_idx_d = byte_idx_q + 3'd1;
            blk_cnt_d  = (blk_cnt_q == BLK_LAST) ? 8'd0 : blk_cnt_q + 8'd1;
            if (byte_idx_q == 3'd7) begin
                out_valid_d = 1'b1;
                blk_end_d   = (blk_cnt_q == BLK_LAST);
                last_d      = final_blk && (blk_cnt_q == BLK_LAST);
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_word      = lane_q;
    assign bus.out_block_end = blk_end_q;
    assign bus.out_last      = last_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
endmodule

// File: tb/tb_kmac_bytepad_packer.sv
module tb_kmac_bytepad_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmac_bytepad_if ifa ();
    kmac_bytepad_if ifb ();

    kmac_bytepad_packer #(.RATE_BYTES(168)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    kmac_bytepad_packer #(.RATE_BYTES(136)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Shared stimulus is steered to one instance at a time by sel.
    int          sel;
    logic        start, in_valid, in_last, out_ready;
    logic [7:0]  in_byte;

    assign ifa.start     = start && (sel == 0);
    assign ifa.in_valid  = in_valid && (sel == 0);
    assign ifa.in_byte   = in_byte;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready && (sel == 0);
    assign ifb.start     = start && (sel == 1);
    assign ifb.in_valid  = in_valid && (sel == 1);
    assign ifb.in_byte   = in_byte;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready && (sel == 1);

    logic        o_in_ready, o_valid, o_blk, o_last, o_busy, o_done;
    logic [63:0] o_word;
    assign o_in_ready = (sel == 1) ? ifb.in_ready      : ifa.in_ready;
    assign o_valid    = (sel == 1) ? ifb.out_valid     : ifa.out_valid;
    assign o_word     = (sel == 1) ? ifb.out_word      : ifa.out_word;
    assign o_blk      = (sel == 1) ? ifb.out_block_end : ifa.out_block_end;
    assign o_last     = (sel == 1) ? ifb.out_last      : ifa.out_last;
    assign o_busy     = (sel == 1) ? ifb.busy          : ifa.busy;
    assign o_done     = (sel == 1) ? ifb.done          : ifa.done;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] din[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'(0));
        chk({tag, "_word"}, o_word, 64'(0));
        chk({tag, "_blk_end"}, 64'(o_blk), 64'(0));
        chk({tag, "_last"}, 64'(o_last), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_done"}, 64'(o_done), 64'(0));
        chk({tag, "_in_ready"}, 64'(o_in_ready), 64'(0));
    endtask

    // mode 0: no stalls, input always valid; 1: random stalls and stray starts;
    // 2: out_ready pattern 1-0-0-1. abort_lane >= 0 resets after that many lanes.
    task automatic run_frame(input int mode, input int abort_lane);
        logic [7:0]  exp_b[$];
        logic [63:0] exp_w[$];
        logic [63:0] w, h_word;
        logic        h_blk, h_last, pend, fin, iv;
        int          rate_l, nexp, idx, got, c, first;

        rate_l = (sel == 1) ? 136 : 168;
        exp_b = {};
        exp_b.push_back(8'h01);
        exp_b.push_back(8'(rate_l));
        foreach (din[i]) exp_b.push_back(din[i]);
        while (exp_b.size() % rate_l != 0) exp_b.push_back(8'h00);
        nexp = exp_b.size() / 8;
        exp_w = {};
        for (int k = 0; k < nexp; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = w | (64'(exp_b[8*k+j]) << (8*j));
            exp_w.push_back(w);
        end

        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; got = 0; c = 0; first = -1; pend = 1'b0; fin = 1'b0;
        h_word = '0; h_blk = 1'b0; h_last = 1'b0;

        while (!fin && c < 4000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            endcase
            iv = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (idx < din.size()) begin
                in_valid = iv;
                in_byte  = din[idx];
                in_last  = (idx == din.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                in_last  = 1'b0;
            end
            start = (mode == 1) && o_busy && ($urandom_range(0, 7) == 0);
            #1;
            if (first < 0 && o_valid) begin
                first = c;
                if (mode == 0 && abort_lane < 0) chk("first_lane_latency", 64'(c), 64'(8));
            end
            if (pend) begin
                chk("stall_valid", 64'(o_valid), 64'(1));
                chk("stall_word", o_word, h_word);
                chk("stall_blk_end", 64'(o_blk), 64'(h_blk));
                chk("stall_last", 64'(o_last), 64'(h_last));
            end
            if (o_valid && !out_ready) chk("in_ready_stall", 64'(o_in_ready), 64'(0));
            if (in_valid && o_in_ready) idx++;
            if (o_valid && out_ready) begin
                if (got < nexp) begin
                    chk("lane_word", o_word, exp_w[got]);
                    chk("lane_blk_end", 64'(o_blk), 64'(((got + 1) * 8) % rate_l == 0));
                    chk("lane_last", 64'(o_last), 64'(got == nexp - 1));
                end else begin
                    chk("extra_lane", 64'(got), 64'(nexp - 1));
                end
                got++;
                if (o_last) fin = 1'b1;
            end
            pend   = o_valid && !out_ready;
            h_word = o_word; h_blk = o_blk; h_last = o_last;
            if (abort_lane >= 0 && got == abort_lane) begin
                rst = 1'b1;
                #1;
                chk_idle("abort");
                in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk_idle("post_abort");
                return;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!fin) chk("frame_timeout", 64'(c), 64'(0));
        chk("lane_count", 64'(got), 64'(nexp));
        chk("done_pulse", 64'(o_done), 64'(1));
        chk("busy_after_done", 64'(o_busy), 64'(0));
        @(negedge clk);
        chk("done_single", 64'(o_done), 64'(0));
    endtask

    task automatic rand_din(input int n);
        din = {};
        for (int i = 0; i < n; i++) din.push_back(8'($urandom));
    endtask

    initial begin
        sel = 0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_byte = 8'h00;
        rst = 1'b1;
        #1;
        chk_idle("reset_a");
        sel = 1;
        #1;
        chk_idle("reset_b");
        sel = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        din = {8'hAA, 8'hBB, 8'hCC};
        run_frame(0, -1);
        rand_din(166);
        run_frame(1, -1);
        rand_din(167);
        run_frame(0, -1);
        rand_din(20);
        run_frame(2, -1);
        rand_din(200);
        run_frame(0, 5);
        rand_din(30);
        run_frame(0, -1);

        sel = 1;
        din = {8'h55};
        run_frame(0, -1);
        rand_din(134);
        run_frame(2, -1);

        for (int t = 0; t < 6; t++) begin
            sel = t % 2;
            rand_din(int'($urandom_range(1, 350)));
            run_frame(1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
